bus85_memctl: RTL and testbench

Synchronous bus-slave memory controller for the core85 multiplexed 8085 bus. It demultiplexes AD[7:0] using ALE and decodes IO/M#, RD# and WR#. It turns bus cycles inside a configurable window into single-cycle requests on a synchronous RAM port. It returns read data on the AD bus and holds READY low for the required wait states.

---
 rtl/bus85_memctl_if.sv | 27 ++
 rtl/bus85_memctl.sv | 157 +++++++++++++++
 tb/tb_bus85_memctl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus85_memctl_if.sv
// Multiplexed 8085 bus signals seen by the memory controller.
// The master side drives address, data-in and strobes; the slave side returns data and status.
interface bus85_memctl_if #(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 16
);
    logic [DATASIZE-1:0]          ad_i;
    logic [ADDRSIZE-DATASIZE-1:0] addr_hi;
    logic                         ale;
    logic                         iom_;
    logic                         rd_;
    logic                         wr_;
    logic [DATASIZE-1:0]          ad_o;
    logic                         ad_oe;
    logic                         ready;
    logic                         bus_err;

    modport master (
        output ad_i, addr_hi, ale, iom_, rd_, wr_,
        input  ad_o, ad_oe, ready, bus_err
    );

    modport slave (
        input  ad_i, addr_hi, ale, iom_, rd_, wr_,
        output ad_o, ad_oe, ready, bus_err
    );
endinterface

// File: rtl/bus85_memctl.sv
// 8085 bus slave: demultiplexes AD with ALE and maps a 2**MEMBITS window onto a
// synchronous RAM, holding READY low while read data is fetched and buffered.
module bus85_memctl #(
    parameter int unsigned         DATASIZE = 8,
    parameter int unsigned         ADDRSIZE = 16,
    parameter int unsigned         MEMBITS  = 12,
    parameter logic [ADDRSIZE-1:0] MEMBASE  = 16'h0000,
    parameter int unsigned         WAITCNT  = 1
) (
    input  logic                clk,
    input  logic                rst_,
    bus85_memctl_if.slave       bus,
    output logic [MEMBITS-1:0]  mem_addr,
    output logic                mem_re,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic                mem_we,
    output logic [DATASIZE-1:0] mem_wdata
);
    localparam logic [3:0] WaitInit = 4'(WAITCNT);

    typedef enum logic [2:0] {StIdle, StRdReq, StRdCap, StRdWait, StDrive, StWrCap} state_e;

    state_e              state_q, state_d;
    logic [ADDRSIZE-1:0] alat_q;
    logic [DATASIZE-1:0] dbuf_q, dbuf_d;
    logic [DATASIZE-1:0] wbuf_q, wbuf_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [MEMBITS-1:0]  mem_addr_q, mem_addr_d;
    logic                mem_re_q, mem_re_d;
    logic                mem_we_q, mem_we_d;
    logic [DATASIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                ad_oe_q, ad_oe_d;
    logic                ready_q, ready_d;
    logic                bus_err_q, bus_err_d;
    logic                sel;

    assign sel = !bus.iom_ && (alat_q[ADDRSIZE-1:MEMBITS] == MEMBASE[ADDRSIZE-1:MEMBITS]);

    // The address latch runs regardless of FSM state; mem_addr keeps the transaction address.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            alat_q <= '0;
        end else if (bus.ale) begin
            alat_q <= {bus.addr_hi, bus.ad_i};
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= StIdle;
            dbuf_q      <= '0;
            wbuf_q      <= '0;
            wcnt_q      <= '0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            ad_oe_q     <= 1'b0;
            ready_q     <= 1'b1;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dbuf_q      <= dbuf_d;
            wbuf_q      <= wbuf_d;
            wcnt_q      <= wcnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            ad_oe_q     <= ad_oe_d;
            ready_q     <= ready_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dbuf_d      = dbuf_q;
        wbuf_d      = wbuf_q;
        wcnt_d      = wcnt_q;
        mem_addr_d  = mem_addr_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        ad_oe_d     = ad_oe_q;
        ready_d     = ready_q;
        bus_err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!bus.rd_ && !bus.wr_) begin
                    bus_err_d = 1'b1;
                end else if (!bus.rd_ && sel) begin
                    state_d    = StRdReq;
                    mem_addr_d = alat_q[MEMBITS-1:0];
                    mem_re_d   = 1'b1;
                    ready_d    = 1'b0;
                end else if (!bus.wr_ && sel) begin
                    state_d    = StWrCap;
                    mem_addr_d = alat_q[MEMBITS-1:0];
                    wbuf_d     = bus.ad_i;
                end
            end
            StRdReq, StRdCap, StRdWait: begin
                if (bus.rd_) begin
                    // Master gave up the read: release READY and never drive AD.
                    state_d = StIdle;
                    ready_d = 1'b1;
                    ad_oe_d = 1'b0;
                end else if (state_q == StRdReq) begin
                    state_d = StRdCap;
                end else if (state_q == StRdCap) begin
                    dbuf_d = mem_rdata;
                    wcnt_d = WaitInit;
                    if (WAITCNT == 0) begin
                        state_d = StDrive;
                        ad_oe_d = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        state_d = StRdWait;
                    end
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) begin
                        state_d = StDrive;
                        ad_oe_d = 1'b1;
                        ready_d = 1'b1;
                    end
                end
            end
            StDrive: begin
                if (bus.rd_) begin
                    state_d = StIdle;
                    ad_oe_d = 1'b0;
                end
            end
            StWrCap: begin
                if (!bus.wr_) begin
                    wbuf_d = bus.ad_i;
                end else begin
                    state_d     = StIdle;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = wbuf_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.ad_o    = dbuf_q;
    assign bus.ad_oe   = ad_oe_q && !bus.ale;
    assign bus.ready   = ready_q;
    assign bus.bus_err = bus_err_q;
    assign mem_addr    = mem_addr_q;
    assign mem_re      = mem_re_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_bus85_memctl.sv
// Directed bench: four controller configurations share one bus stimulus, each with its own RAM.
module tb_bus85_memctl;
    logic        clk;
    logic        rst_;
    logic [7:0]  ad_i;
    logic [7:0]  addr_hi;
    logic        ale, iom_, rd_, wr_;

    logic [11:0] maddr  [4];
    logic        mre    [4];
    logic        mwe    [4];
    logic [7:0]  mwdata [4];
    logic [7:0]  mrdata [4];
    logic        rdy    [4];
    logic        oe     [4];
    logic        berr   [4];
    logic [7:0]  ado    [4];

    bus85_memctl_if if_a ();
    bus85_memctl_if if_b ();
    bus85_memctl_if if_c ();
    bus85_memctl_if if_d ();

    assign if_a.ad_i = ad_i; assign if_a.addr_hi = addr_hi; assign if_a.ale = ale;
    assign if_a.iom_ = iom_; assign if_a.rd_ = rd_; assign if_a.wr_ = wr_;
    assign if_b.ad_i = ad_i; assign if_b.addr_hi = addr_hi; assign if_b.ale = ale;
    assign if_b.iom_ = iom_; assign if_b.rd_ = rd_; assign if_b.wr_ = wr_;
    assign if_c.ad_i = ad_i; assign if_c.addr_hi = addr_hi; assign if_c.ale = ale;
    assign if_c.iom_ = iom_; assign if_c.rd_ = rd_; assign if_c.wr_ = wr_;
    assign if_d.ad_i = ad_i; assign if_d.addr_hi = addr_hi; assign if_d.ale = ale;
    assign if_d.iom_ = iom_; assign if_d.rd_ = rd_; assign if_d.wr_ = wr_;

    assign rdy[0] = if_a.ready; assign oe[0] = if_a.ad_oe;
    assign berr[0] = if_a.bus_err; assign ado[0] = if_a.ad_o;
    assign rdy[1] = if_b.ready; assign oe[1] = if_b.ad_oe;
    assign berr[1] = if_b.bus_err; assign ado[1] = if_b.ad_o;
    assign rdy[2] = if_c.ready; assign oe[2] = if_c.ad_oe;
    assign berr[2] = if_c.bus_err; assign ado[2] = if_c.ad_o;
    assign rdy[3] = if_d.ready; assign oe[3] = if_d.ad_oe;
    assign berr[3] = if_d.bus_err; assign ado[3] = if_d.ad_o;

    bus85_memctl #(.MEMBASE(16'h0000), .WAITCNT(1)) u_a (
        .clk(clk), .rst_(rst_), .bus(if_a), .mem_addr(maddr[0]), .mem_re(mre[0]),
        .mem_rdata(mrdata[0]), .mem_we(mwe[0]), .mem_wdata(mwdata[0]));
    bus85_memctl #(.MEMBASE(16'h0000), .WAITCNT(0)) u_b (
        .clk(clk), .rst_(rst_), .bus(if_b), .mem_addr(maddr[1]), .mem_re(mre[1]),
        .mem_rdata(mrdata[1]), .mem_we(mwe[1]), .mem_wdata(mwdata[1]));
    bus85_memctl #(.MEMBASE(16'h8000), .WAITCNT(1)) u_c (
        .clk(clk), .rst_(rst_), .bus(if_c), .mem_addr(maddr[2]), .mem_re(mre[2]),
        .mem_rdata(mrdata[2]), .mem_we(mwe[2]), .mem_wdata(mwdata[2]));
    bus85_memctl #(.MEMBASE(16'h0000), .WAITCNT(4)) u_d (
        .clk(clk), .rst_(rst_), .bus(if_d), .mem_addr(maddr[3]), .mem_re(mre[3]),
        .mem_rdata(mrdata[3]), .mem_we(mwe[3]), .mem_wdata(mwdata[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [4][4096];
    int re_cnt [4], we_cnt [4], be_cnt [4];
    int re_s   [4], we_s   [4], be_s   [4];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mwe[i]) ram[i][maddr[i]] <= mwdata[i];
            if (mre[i]) mrdata[i] <= ram[i][maddr[i]];
            if (mre[i]) re_cnt[i] <= re_cnt[i] + 1;
            if (mwe[i]) we_cnt[i] <= we_cnt[i] + 1;
            if (berr[i]) be_cnt[i] <= be_cnt[i] + 1;
        end
    end

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic       h_rdy [4][16];
    logic       h_oe  [4][16];
    logic [7:0] h_ado [4][16];
    logic       h_re  [4][16];
    logic       r_rdy [4];
    logic       r_oe  [4];
    logic        w_we [4];
    logic        w_we_after [4];
    logic [11:0] w_addr [4];
    logic [7:0]  w_wdata [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) begin
            re_s[i] = re_cnt[i]; we_s[i] = we_cnt[i]; be_s[i] = be_cnt[i];
        end
    endtask

    task automatic latch(input logic [15:0] addr, input logic iom);
        ad_i = addr[7:0]; addr_hi = addr[15:8]; iom_ = iom; ale = 1'b1;
        tick();
        ale = 1'b0;
    endtask

    task automatic write_cycle(input logic [15:0] addr, input logic [7:0] d0, input logic [7:0] d1);
        latch(addr, 1'b0);
        ad_i = d0; wr_ = 1'b0;
        tick();
        ad_i = d1;
        tick();
        ad_i = 8'h00; wr_ = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            w_we[i] = mwe[i]; w_addr[i] = maddr[i]; w_wdata[i] = mwdata[i];
        end
        tick();
        for (int i = 0; i < 4; i++) w_we_after[i] = mwe[i];
        tick();
    endtask

    task automatic read_cycle(input logic [15:0] addr, input logic iom, input int hold);
        latch(addr, iom);
        rd_ = 1'b0;
        for (int k = 0; k < hold; k++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                h_rdy[i][k] = rdy[i]; h_oe[i][k] = oe[i]; h_ado[i][k] = ado[i]; h_re[i][k] = mre[i];
            end
        end
        rd_ = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            r_rdy[i] = rdy[i]; r_oe[i] = oe[i];
        end
        tick();
        iom_ = 1'b0;
    endtask

    function automatic int low_run(input int i, input int hold);
        int n = 0;
        for (int k = 0; k < hold; k++) begin
            if (h_rdy[i][k]) break;
            n++;
        end
        return n;
    endfunction

    function automatic int first_oe(input int i, input int hold);
        for (int k = 0; k < hold; k++) begin
            if (h_oe[i][k]) return k;
        end
        return hold;
    endfunction

    initial begin
        rst_ = 1'b1; ad_i = 8'h00; addr_hi = 8'h00; ale = 1'b0; iom_ = 1'b0;
        rd_ = 1'b1; wr_ = 1'b1;
        #2 rst_ = 1'b0;
        #1;
        check("rst_ready", rdy[0], 1);
        check("rst_ad_oe", oe[0], 0);
        check("rst_ad_o", ado[0], 0);
        check("rst_bus_err", berr[0], 0);
        check("rst_mem_addr", maddr[0], 0);
        check("rst_mem_re", mre[0], 0);
        check("rst_mem_we", mwe[0], 0);
        check("rst_mem_wdata", mwdata[0], 0);
        check("rst_ready_d", rdy[3], 1);
        #10 rst_ = 1'b1;
        tick();

        snap();
        write_cycle(16'h0123, 8'hA5, 8'hA5);
        check("wr_we_pulse", w_we[0], 1);
        check("wr_addr", w_addr[0], 12'h123);
        check("wr_wdata", w_wdata[0], 8'hA5);
        check("wr_we_clears", w_we_after[0], 0);
        check("wr_we_count", we_cnt[0] - we_s[0], 1);
        check("wr_outside_window", we_cnt[2] - we_s[2], 0);

        write_cycle(16'h0042, 8'h11, 8'h3C);
        check("wr_last_data", w_wdata[3], 8'h3C);
        check("wr_last_addr", w_addr[3], 12'h042);

        snap();
        read_cycle(16'h0123, 1'b0, 8);
        check("rd_w1_mem_re", h_re[0][0], 1);
        check("rd_w1_addr", maddr[0], 12'h123);
        check("rd_w1_ready_low", low_run(0, 8), 3);
        check("rd_w1_oe_rise", first_oe(0, 8), 3);
        check("rd_w1_data", h_ado[0][3], 8'hA5);
        check("rd_w1_oe_held", h_oe[0][7], 1);
        check("rd_w1_oe_release", r_oe[0], 0);
        check("rd_w0_ready_low", low_run(1, 8), 2);
        check("rd_w0_oe_rise", first_oe(1, 8), 2);
        check("rd_w0_data", h_ado[1][2], 8'hA5);
        check("rd_w4_ready_low", low_run(3, 8), 6);
        check("rd_w4_oe_rise", first_oe(3, 8), 6);
        check("rd_w4_data", h_ado[3][6], 8'hA5);
        check("rd_out_ready", low_run(2, 8), 0);
        check("rd_out_oe", first_oe(2, 8), 8);
        check("rd_out_re", re_cnt[2] - re_s[2], 0);

        snap();
        read_cycle(16'h8010, 1'b1, 4);
        check("io_ready", low_run(2, 4), 0);
        check("io_oe", first_oe(2, 4), 4);
        check("io_re_c", re_cnt[2] - re_s[2], 0);
        check("io_re_a", re_cnt[0] - re_s[0], 0);

        read_cycle(16'h0123, 1'b0, 4);
        check("abort_ready_low", low_run(3, 4), 4);
        check("abort_no_oe", first_oe(3, 4), 4);
        check("abort_ready_back", r_rdy[3], 1);
        check("abort_oe_after", r_oe[3], 0);
        write_cycle(16'h0055, 8'h77, 8'h77);
        check("abort_next_we", w_we[3], 1);
        check("abort_next_wdata", w_wdata[3], 8'h77);

        snap();
        latch(16'h0123, 1'b0);
        rd_ = 1'b0; wr_ = 1'b0;
        tick();
        check("berr_pulse", berr[0], 1);
        rd_ = 1'b1; wr_ = 1'b1;
        tick();
        check("berr_clear", berr[0], 0);
        tick();
        check("berr_count", be_cnt[0] - be_s[0], 1);
        check("berr_no_re", re_cnt[0] - re_s[0], 0);
        check("berr_no_we", we_cnt[0] - we_s[0], 0);

        latch(16'h0042, 1'b0);
        rd_ = 1'b0;
        repeat (4) tick();
        check("mid_rd_busy", rdy[3], 0);
        #3 rst_ = 1'b0;
        #1;
        check("mid_rst_ready", rdy[3], 1);
        check("mid_rst_oe", oe[3], 0);
        check("mid_rst_addr", maddr[3], 0);
        check("mid_rst_re", mre[3], 0);
        rd_ = 1'b1;
        #2 rst_ = 1'b1;
        tick();
        read_cycle(16'h0042, 1'b0, 8);
        check("post_rst_oe_rise", first_oe(3, 8), 6);
        check("post_rst_data", h_ado[3][6], 8'h3C);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
